// File: rtl/adder.sv
// Pipelined four-operand unsigned adder with a saturated, registered result.
// Stages: operand capture, pairwise sums, full sum with saturation into out.

module adder_pair #(
   parameter int DATA_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W:0]   sum
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum <= '0;
      else        sum <= {1'b0, a} + {1'b0, b};
   end
endmodule

module adder #(
   parameter  int DATA_W = 14,
   localparam int OUT_W  = DATA_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [DATA_W-1:0] in4,
   output logic [OUT_W-1:0]  out
);
   localparam int NUM_OPS = 4;
   localparam int NUM_PAIRS = NUM_OPS / 2;

   logic [NUM_OPS-1:0][DATA_W-1:0] s1_op;
   logic [NUM_PAIRS-1:0][DATA_W:0] s2_sum;
   logic [DATA_W+1:0]              full_sum;
   logic [OUT_W-1:0]               sat_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s1_op <= '0;
      else        s1_op <= {in4, in3, in2, in1};
   end

   // Pair g adds operands 2g and 2g+1: (in1+in2) and (in3+in4).
   for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_pair
      adder_pair #(.DATA_W(DATA_W)) u_pair (
         .clk   (clk),
         .rst_n (rst_n),
         .a     (s1_op[2*g]),
         .b     (s1_op[2*g+1]),
         .sum   (s2_sum[g])
      );
   end

   always_comb begin
      full_sum = {1'b0, s2_sum[0]} + {1'b0, s2_sum[1]};
      sat_sum  = full_sum[DATA_W+1] ? {OUT_W{1'b1}} : full_sum[OUT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out <= '0;
      else        out <= sat_sum;
   end
endmodule

// File: tb/tb_adder.sv
// Directed-vector bench for the four-operand saturating adder.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_adder;
   localparam int DATA_W = 14;
   localparam int OUT_W  = DATA_W + 1;
   localparam int NVEC   = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DATA_W-1:0] in1, in2, in3, in4;
   logic [OUT_W-1:0]  out;

   int total = 0;
   int bad   = 0;

   int ops  [NVEC][4];
   int expv [NVEC];

   adder #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in1   (in1),
      .in2   (in2),
      .in3   (in3),
      .in4   (in4),
      .out   (out)
   );

   always #4 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic drive(input int a, input int b, input int c, input int d);
      in1 = DATA_W'(a);
      in2 = DATA_W'(b);
      in3 = DATA_W'(c);
      in4 = DATA_W'(d);
   endtask

   initial begin
      ops[0] = '{1111, 1111, 1111, 1111};     expv[0] = 4444;
      ops[1] = '{3333, 3333, 3333, 3333};     expv[1] = 13332;
      ops[2] = '{5555, 5555, 5555, 5555};     expv[2] = 22220;
      ops[3] = '{16383, 16383, 16383, 16383}; expv[3] = 32767;
      ops[4] = '{8192, 8192, 8192, 8192};     expv[4] = 32767;
      ops[5] = '{8191, 8192, 8192, 8192};     expv[5] = 32767;
      ops[6] = '{8191, 8191, 8192, 8192};     expv[6] = 32766;
      ops[7] = '{1, 0, 16383, 2};             expv[7] = 16386;

      rst_n = 1'b0;
      drive(0, 0, 0, 0);
      #1 chk("reset_t1", int'(out), 0);
      #9 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_reset_zero", int'(out), 0);
      end

      // Basic sum: nothing appears until two edges after the sampling edge.
      drive(1111, 1111, 1111, 1111);
      @(negedge clk); chk("basic_lat1", int'(out), 0);
      @(negedge clk); chk("basic_lat2", int'(out), 0);
      @(negedge clk); chk("basic_sum", int'(out), 4444);
      @(negedge clk); chk("basic_hold", int'(out), 4444);

      // Back-to-back table: streaming, saturation boundaries, mixed operands.
      for (int i = 0; i < NVEC + 3; i++) begin
         @(negedge clk);
         if (i >= 3) chk($sformatf("vec%0d", i - 3), int'(out), expv[i-3]);
         if (i < NVEC) drive(ops[i][0], ops[i][1], ops[i][2], ops[i][3]);
      end
      @(negedge clk); chk("mixed_steady", int'(out), 16386);

      // Asynchronous reset mid-stream.
      drive(5555, 5555, 5555, 5555);
      repeat (3) @(negedge clk);
      chk("pre_reset_sum", int'(out), 22220);
      #2 rst_n = 1'b0;
      #1 chk("async_clear", int'(out), 0);
      @(negedge clk); chk("held_in_reset", int'(out), 0);
      rst_n = 1'b1;
      @(negedge clk); chk("rel_lat1", int'(out), 0);
      @(negedge clk); chk("rel_lat2", int'(out), 0);
      @(negedge clk); chk("rel_sum", int'(out), 22220);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
